uart_tx_slave: RTL

//  Memory-mapped UART transmitter that responds on the core's valid/ready data-memory bus, sitting

---
 rtl/uart_tx_slave.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt on the valid/ready data bus.
// Optional parity frame bit is built in when UART_TX_PARITY_EN is defined.
module uart_tx_slave #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] BIDLE = 1'b0;
  localparam logic [0:0] BRESP = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [0:0]  r_bst;
  logic [31:0] r_rdata;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_cnt;
  logic        r_ovf, r_irq_en, r_irq, r_tx;
  logic [15:0] r_div, r_baud;
  logic [2:0]  r_txst, r_bit;
  logic [7:0]  r_shift;
`ifdef UART_TX_PARITY_EN
  logic        r_par_en, r_odd, r_par, r_fpar;
`endif

  logic        w_acc, w_wr, w_full, w_empty, w_busy, w_push_req, w_push, w_bit_end, w_load;
  logic [1:0]  w_sel;
  logic [31:0] w_ctrl, w_rval;
  logic        w_unused;

  assign w_sel      = addr_i[3:2];
  assign w_acc      = (r_bst == BIDLE) & valid_i;
  assign w_wr       = w_acc & (|we_i);
  assign w_full     = (r_cnt == CNT_FULL);
  assign w_empty    = (r_cnt == '0);
  assign w_busy     = (r_txst != S_IDLE);
  assign w_push_req = w_wr & (w_sel == 2'd0) & we_i[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_bit_end  = (r_baud == 16'd0);
  // Popping at the end of a stop bit lets the next start bit follow with no idle gap.
  assign w_load     = ~w_empty & ((r_txst == S_IDLE) | ((r_txst == S_STOP) & w_bit_end));
  assign w_unused   = &{1'b0, addr_i[31:4], addr_i[1:0], wdata_i[31:16]};

`ifdef UART_TX_PARITY_EN
  assign w_ctrl = {29'd0, r_odd, r_par_en, r_irq_en};
`else
  assign w_ctrl = {31'd0, r_irq_en};
`endif

  always_comb begin
    w_rval = 32'd0;
    case (w_sel)
      2'd1:    w_rval = {28'd0, r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_rval = w_ctrl;
      2'd3:    w_rval = {16'd0, r_div};
      default: w_rval = 32'd0;
    endcase
  end

  // rdata is only loaded on entry to BRESP and cleared on exit, so it reads 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bst   <= BIDLE;
      r_rdata <= 32'd0;
    end else if (r_bst == BRESP) begin
      r_bst   <= BIDLE;
      r_rdata <= 32'd0;
    end else if (valid_i) begin
      r_bst   <= BRESP;
      r_rdata <= (we_i == 4'b0000) ? w_rval : 32'd0;
    end
  end

  assign ready_o = (r_bst == BRESP);
  assign rdata_o = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
      r_par_en <= 1'b0;
      r_odd    <= 1'b0;
`endif
    end else begin
      if (w_push_req & w_full) r_ovf <= 1'b1;
      if (w_wr) begin
        case (w_sel)
          2'd1: if (we_i[0] & wdata_i[3]) r_ovf <= 1'b0;
          2'd2: if (we_i[0]) begin
            r_irq_en <= wdata_i[0];
`ifdef UART_TX_PARITY_EN
            r_par_en <= wdata_i[1];
            r_odd    <= wdata_i[2];
`endif
          end
          2'd3: begin
            if (we_i[0]) r_div[7:0]  <= wdata_i[7:0];
            if (we_i[1]) r_div[15:8] <= wdata_i[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_load) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Every bit boundary reloads the counter from the live divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txst  <= S_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
      r_fpar  <= 1'b0;
`endif
    end else if (w_load) begin
      r_txst  <= S_START;
      r_baud  <= r_div;
      r_shift <= r_mem[r_rptr];
      r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= (^r_mem[r_rptr]) ^ r_odd;
      r_fpar  <= r_par_en;
`endif
    end else begin
      case (r_txst)
        S_IDLE: ;
        S_START: if (w_bit_end) begin
          r_txst <= S_DATA;
          r_baud <= r_div;
          r_bit  <= 3'd0;
          r_tx   <= r_shift[0];
        end else r_baud <= r_baud - 16'd1;
        S_DATA: if (w_bit_end) begin
          r_baud <= r_div;
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (r_fpar) begin
              r_txst <= S_PARITY;
              r_tx   <= r_par;
            end else begin
              r_txst <= S_STOP;
              r_tx   <= 1'b1;
            end
`else
            r_txst <= S_STOP;
            r_tx   <= 1'b1;
`endif
          end else begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            r_tx    <= r_shift[1];
          end
        end else r_baud <= r_baud - 16'd1;
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (w_bit_end) begin
          r_txst <= S_STOP;
          r_baud <= r_div;
          r_tx   <= 1'b1;
        end else r_baud <= r_baud - 16'd1;
`endif
        S_STOP: if (w_bit_end) begin
          r_txst <= S_IDLE;
          r_tx   <= 1'b1;
        end else r_baud <= r_baud - 16'd1;
        default: begin
          r_txst <= S_IDLE;
          r_tx   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_irq_en & w_empty & ~w_busy;
  end

  assign tx_o  = r_tx;
  assign irq_o = r_irq;
endmodule
